// File: rtl/rp_acq_pkg.sv
// Acquisition-control shared types: FSM state encoding and trigger source codes.
// Pure definitions, no logic; no latency or flow-control implications.
package rp_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ARM  = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } acq_state_e;

  // 0 disables triggering; 2..13 are rising/falling edges of the named source
  localparam logic [3:0] TRG_SRC_NONE    = 4'd0;
  localparam logic [3:0] TRG_SRC_MANUAL  = 4'd1;
  localparam logic [3:0] TRG_SRC_CHA_PE  = 4'd2;
  localparam logic [3:0] TRG_SRC_CHA_NE  = 4'd3;
  localparam logic [3:0] TRG_SRC_CHB_PE  = 4'd4;
  localparam logic [3:0] TRG_SRC_CHB_NE  = 4'd5;
  localparam logic [3:0] TRG_SRC_EXT_PE  = 4'd6;
  localparam logic [3:0] TRG_SRC_EXT_NE  = 4'd7;
  localparam logic [3:0] TRG_SRC_ASG_PE  = 4'd8;
  localparam logic [3:0] TRG_SRC_ASG_NE  = 4'd9;
  localparam logic [3:0] TRG_SRC_CHC_PE  = 4'd10;
  localparam logic [3:0] TRG_SRC_CHC_NE  = 4'd11;
  localparam logic [3:0] TRG_SRC_CHD_PE  = 4'd12;
  localparam logic [3:0] TRG_SRC_CHD_NE  = 4'd13;

  function automatic logic state_is_busy(acq_state_e s);
    return (s == ST_PRE) || (s == ST_ARM) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/rp_acq_cnt.sv
// Sample counter with synchronous clear (wins over enable) and combinational equality match.
// Count updates 1 cycle after enable; match reflects the registered count; no backpressure.
module rp_acq_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] cmp_i,
  output logic [W-1:0] cnt_o,
  output logic         match_o
);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

  assign match_o = (cnt_o == cmp_i);

endmodule

// File: rtl/rp_acq_ctrl.sv
// Acquisition FSM (IDLE->PRE->ARM->POST->DONE); all pulses registered, 1 cycle after the cause; no backpressure.
// Define ACQ_TIMESTAMP_EN to add a free-running cycle counter captured on the accepted trigger (trig_ts_o).
module rp_acq_ctrl
  import rp_acq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             adc_clk_i,
  input  logic             adc_rstn_i,
  input  logic             arm_i,
  input  logic             stop_i,
  input  logic             dly_valp_i,
  input  logic             trig_i,
  input  logic [3:0]       cfg_src_i,
  input  logic [CNT_W-1:0] cfg_pre_i,
  input  logic [CNT_W-1:0] cfg_post_i,
  output logic             set_trg_new_o,
  output logic [3:0]       set_trg_src_o,
  output logic             trig_dis_clr_o,
  output logic             adc_rst_do_o,
  output logic             adc_dly_do_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             done_o
`ifdef ACQ_TIMESTAMP_EN
  ,
  output logic [CNT_W-1:0] trig_ts_o
`endif
);

  acq_state_e       state;
  logic [3:0]       src_lat;
  logic [CNT_W-1:0] pre_lat;
  logic [CNT_W-1:0] post_lat;

  logic             abort;
  logic             arm_acc;
  logic             trig_acc;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_match;
  logic [CNT_W-1:0] cnt_cmp;
  logic [CNT_W-1:0] cnt_val;

  // stop outranks every other event, except in IDLE where it is meaningless
  assign abort    = stop_i && (state != ST_IDLE);
  assign arm_acc  = arm_i && !abort && ((state == ST_IDLE) || (state == ST_DONE));
  assign trig_acc = trig_i && !abort && (state == ST_ARM);

  assign cnt_clr = arm_acc || trig_acc;
  assign cnt_en  = dly_valp_i && !cnt_match && ((state == ST_PRE) || (state == ST_POST));
  assign cnt_cmp = (state == ST_PRE) ? pre_lat : post_lat;

  rp_acq_cnt #(
    .W (CNT_W)
  ) u_smp_cnt (
    .clk_i   (adc_clk_i),
    .rstn_i  (adc_rstn_i),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .cmp_i   (cnt_cmp),
    .cnt_o   (cnt_val),
    .match_o (cnt_match)
  );

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state          <= ST_IDLE;
      src_lat        <= '0;
      pre_lat        <= '0;
      post_lat       <= '0;
      set_trg_new_o  <= 1'b0;
      set_trg_src_o  <= '0;
      trig_dis_clr_o <= 1'b0;
      adc_rst_do_o   <= 1'b0;
      adc_dly_do_o   <= 1'b0;
    end else begin
      set_trg_new_o  <= 1'b0;
      trig_dis_clr_o <= 1'b0;
      adc_rst_do_o   <= 1'b0;
      adc_dly_do_o   <= 1'b0;
      if (abort) begin
        state        <= ST_IDLE;
        adc_rst_do_o <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (arm_acc) begin
              src_lat        <= cfg_src_i;
              pre_lat        <= cfg_pre_i;
              post_lat       <= cfg_post_i;
              trig_dis_clr_o <= 1'b1;
              state          <= ST_PRE;
            end
          end
          ST_PRE: begin
            if (cnt_match) begin
              set_trg_new_o <= 1'b1;
              set_trg_src_o <= src_lat;
              state         <= ST_ARM;
            end
          end
          ST_ARM: begin
            if (trig_acc) state <= ST_POST;
          end
          ST_POST: begin
            if (cnt_match) begin
              adc_dly_do_o <= 1'b1;
              state        <= ST_DONE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign state_o = state;
  assign busy_o  = state_is_busy(state);
  assign done_o  = (state == ST_DONE);

`ifdef ACQ_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_cnt;

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      ts_cnt    <= '0;
      trig_ts_o <= '0;
    end else begin
      ts_cnt <= ts_cnt + CNT_W'(1);
      if (trig_acc) trig_ts_o <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_rp_acq_ctrl.sv
// Bench for rp_acq_ctrl: table of per-cycle vectors fed through an expected-output queue, plus reset/timestamp sequences.
module tb_rp_acq_ctrl;
  import rp_acq_pkg::*;

  localparam int CNT_W = 32;
  localparam logic [3:0] P_NO  = 4'b0000;
  localparam logic [3:0] P_CLR = 4'b1000;
  localparam logic [3:0] P_NEW = 4'b0100;
  localparam logic [3:0] P_DLY = 4'b0010;
  localparam logic [3:0] P_RST = 4'b0001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             arm, stop, valp, trig;
  logic [3:0]       cfg_src;
  logic [CNT_W-1:0] cfg_pre, cfg_post;
  logic             set_trg_new, trig_dis_clr, adc_rst_do, adc_dly_do, busy, done;
  logic [3:0]       set_trg_src;
  logic [2:0]       state;
`ifdef ACQ_TIMESTAMP_EN
  logic [CNT_W-1:0] trig_ts;
  logic [CNT_W-1:0] ref_cyc;
  logic [CNT_W-1:0] exp_ts;
`endif

  rp_acq_ctrl #(.CNT_W(CNT_W)) dut (
    .adc_clk_i      (clk),
    .adc_rstn_i     (rst_n),
    .arm_i          (arm),
    .stop_i         (stop),
    .dly_valp_i     (valp),
    .trig_i         (trig),
    .cfg_src_i      (cfg_src),
    .cfg_pre_i      (cfg_pre),
    .cfg_post_i     (cfg_post),
    .set_trg_new_o  (set_trg_new),
    .set_trg_src_o  (set_trg_src),
    .trig_dis_clr_o (trig_dis_clr),
    .adc_rst_do_o   (adc_rst_do),
    .adc_dly_do_o   (adc_dly_do),
    .state_o        (state),
    .busy_o         (busy),
    .done_o         (done)
`ifdef ACQ_TIMESTAMP_EN
    ,
    .trig_ts_o      (trig_ts)
`endif
  );

  always #5 clk = ~clk;

`ifdef ACQ_TIMESTAMP_EN
  // reference cycle count: edges seen since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_cyc <= '0;
    else        ref_cyc <= ref_cyc + 1;
  end
`endif

  typedef struct {
    logic       arm, stop, valp, trig;
    logic [3:0] src;
    logic [7:0] pre, post;
    logic [2:0] st;
    logic [3:0] pls;
    logic [3:0] osrc;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] exp_q[$];
  logic [3:0]  c_src;
  logic [7:0]  c_pre, c_post;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic add(input logic a, input logic s, input logic v, input logic t,
                     input logic [2:0] st, input logic [3:0] pls, input logic [3:0] osrc);
    vec_t r;
    r.arm = a; r.stop = s; r.valp = v; r.trig = t;
    r.src = c_src; r.pre = c_pre; r.post = c_post;
    r.st = st; r.pls = pls; r.osrc = osrc;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [12:0] obs();
    return {state, busy, done, trig_dis_clr, set_trg_new, adc_dly_do, adc_rst_do, set_trg_src};
  endfunction

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    int k = 0;
    while (state !== target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(state), 64'(target));
  endtask

  initial begin
    logic [12:0] e;
    logic        st_busy, st_done;

    rst_n = 1'b0; arm = 1'b1; stop = 1'b0; valp = 1'b1; trig = 1'b1;
    cfg_src = 4'd3; cfg_pre = '0; cfg_post = '0;
    #3;
    check("reset_outputs", 64'(obs()), 64'd0);
    @(posedge clk); #1;
    check("reset_held_over_edge", 64'(obs()), 64'd0);
    @(negedge clk);
    arm = 1'b0; valp = 1'b0; trig = 1'b0;
    rst_n = 1'b1;

    // A: pre=4 post=3 src=2, continuous samples
    c_src = 4'd2; c_pre = 8'd4; c_post = 8'd3;
    add(1,0,1,0, ST_PRE,  P_CLR, 4'd0);
    add(0,0,1,0, ST_PRE,  P_NO,  4'd0);
    add(0,0,1,0, ST_PRE,  P_NO,  4'd0);
    add(0,0,1,0, ST_PRE,  P_NO,  4'd0);
    add(0,0,1,0, ST_PRE,  P_NO,  4'd0);
    add(0,0,1,0, ST_ARM,  P_NEW, 4'd2);
    add(0,0,1,0, ST_ARM,  P_NO,  4'd2);
    add(0,0,1,1, ST_POST, P_NO,  4'd2);
    add(0,0,1,0, ST_POST, P_NO,  4'd2);
    add(0,0,1,0, ST_POST, P_NO,  4'd2);
    add(0,0,1,0, ST_POST, P_NO,  4'd2);
    add(0,0,1,0, ST_DONE, P_DLY, 4'd2);
    add(0,0,0,0, ST_DONE, P_NO,  4'd2);
    // B: pre=0 post=0, re-armed from DONE
    c_src = 4'd5; c_pre = 8'd0; c_post = 8'd0;
    add(1,0,0,0, ST_PRE,  P_CLR, 4'd2);
    add(0,0,0,0, ST_ARM,  P_NEW, 4'd5);
    add(0,0,0,1, ST_POST, P_NO,  4'd5);
    add(0,0,0,0, ST_DONE, P_DLY, 4'd5);
    add(0,0,0,0, ST_DONE, P_NO,  4'd5);
    // C: trigger during PRE is ignored
    c_src = 4'd3; c_pre = 8'd2; c_post = 8'd1;
    add(1,0,0,0, ST_PRE,  P_CLR, 4'd5);
    add(0,0,0,1, ST_PRE,  P_NO,  4'd5);
    add(0,0,1,1, ST_PRE,  P_NO,  4'd5);
    add(0,0,1,0, ST_PRE,  P_NO,  4'd5);
    add(0,0,0,0, ST_ARM,  P_NEW, 4'd3);
    // D: stop beats trigger in ARM; stop in IDLE is inert
    add(0,1,0,1, ST_IDLE, P_RST, 4'd3);
    add(0,0,0,1, ST_IDLE, P_NO,  4'd3);
    add(0,1,0,0, ST_IDLE, P_NO,  4'd3);
    // E: arm in POST ignored, config changes mid-run not used until next arm
    c_src = 4'd7; c_pre = 8'd1; c_post = 8'd2;
    add(1,0,0,0, ST_PRE,  P_CLR, 4'd3);
    add(0,0,1,0, ST_PRE,  P_NO,  4'd3);
    add(0,0,0,0, ST_ARM,  P_NEW, 4'd7);
    add(0,0,0,1, ST_POST, P_NO,  4'd7);
    c_src = 4'd9; c_pre = 8'd0; c_post = 8'd0;
    add(1,0,1,0, ST_POST, P_NO,  4'd7);
    add(0,0,1,0, ST_POST, P_NO,  4'd7);
    add(0,0,0,0, ST_DONE, P_DLY, 4'd7);
    add(1,0,0,0, ST_PRE,  P_CLR, 4'd7);
    add(0,0,0,0, ST_ARM,  P_NEW, 4'd9);
    add(0,1,0,0, ST_IDLE, P_RST, 4'd9);
    // F: stop beats arm and a pending counter match
    add(1,0,0,0, ST_PRE,  P_CLR, 4'd9);
    add(1,1,0,0, ST_IDLE, P_RST, 4'd9);
    add(1,1,0,0, ST_PRE,  P_CLR, 4'd9);
    add(0,0,0,0, ST_ARM,  P_NEW, 4'd9);
    add(0,1,0,0, ST_IDLE, P_RST, 4'd9);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      arm = vecs[i].arm; stop = vecs[i].stop; valp = vecs[i].valp; trig = vecs[i].trig;
      cfg_src = vecs[i].src; cfg_pre = CNT_W'(vecs[i].pre); cfg_post = CNT_W'(vecs[i].post);
      st_busy = (vecs[i].st == 3'd1) || (vecs[i].st == 3'd2) || (vecs[i].st == 3'd3);
      st_done = (vecs[i].st == 3'd4);
      exp_q.push_back({vecs[i].st, st_busy, st_done, vecs[i].pls, vecs[i].osrc});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), 64'(obs()), 64'(e));
    end

    // G: trigger timestamp, then asynchronous reset in POST
    @(negedge clk);
    arm = 1'b1; stop = 1'b0; valp = 1'b0; trig = 1'b0;
    cfg_src = 4'd4; cfg_pre = '0; cfg_post = CNT_W'(5);
    @(posedge clk); #1;
    check("g_enter_pre", 64'(state), 64'(ST_PRE));
    @(negedge clk);
    arm = 1'b0;
    wait_state(ST_ARM, 6, "g_wait_arm");
    @(negedge clk);
    trig = 1'b1;
`ifdef ACQ_TIMESTAMP_EN
    exp_ts = ref_cyc;
`endif
    @(posedge clk); #1;
    check("g_enter_post", 64'(state), 64'(ST_POST));
`ifdef ACQ_TIMESTAMP_EN
    check("g_trig_ts", 64'(trig_ts), 64'(exp_ts));
`endif
    @(negedge clk);
    trig = 1'b0;
    check("g_post_busy_src", 64'({busy, set_trg_src}), 64'({1'b1, 4'd4}));
    #2 rst_n = 1'b0;
    #1;
    check("g_async_reset", 64'(obs()), 64'd0);
`ifdef ACQ_TIMESTAMP_EN
    check("g_ts_reset", 64'(trig_ts), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("g_after_reset_idle", 64'(obs()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rp_acq_ctrl.md
RP_ACQ_CTRL -- requirements
Module: rp_acq_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the sample counters and length settings.
REQ-002 The block SHALL have port adc_clk_i, input, 1 bit: the single ADC clock.
REQ-003 The block SHALL have port adc_rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port arm_i, input, 1 bit: single-cycle pulse that starts an acquisition.
REQ-005 The block SHALL have port stop_i, input, 1 bit: single-cycle pulse that aborts the acquisition.
REQ-006 The block SHALL have port dly_valp_i, input, 1 bit: valid-sample pulse.
REQ-007 The block SHALL have port trig_i, input, 1 bit: trigger from the trigger selector.
REQ-008 The block SHALL have port cfg_src_i, input, 4 bits: trigger source code.
REQ-009 The block SHALL have port cfg_pre_i, input, CNT_W bits: number of pre-trigger samples.
REQ-010 The block SHALL have port cfg_post_i, input, CNT_W bits: number of post-trigger samples.
REQ-011 The block SHALL have output set_trg_new_o, 1 bit: load-source pulse.
REQ-012 The block SHALL have output set_trg_src_o, 4 bits: source value to be loaded.
REQ-013 The block SHALL have output trig_dis_clr_o, 1 bit: re-enable-trigger pulse.
REQ-014 The block SHALL have output adc_rst_do_o, 1 bit: abort pulse.
REQ-015 The block SHALL have output adc_dly_do_o, 1 bit: post-trigger-delay-reached pulse.
REQ-016 The block SHALL have output state_o, 3 bits: current FSM state.
REQ-017 The block SHALL have output busy_o, 1 bit: high in PRE, ARM and POST.
REQ-018 The block SHALL have output done_o, 1 bit: high in DONE.

Function
REQ-019 The FSM states SHALL be IDLE=0, PRE=1, ARM=2, POST=3 and DONE=4; state_o SHALL equal the registered state.
REQ-020 When arm_i is high in IDLE or DONE, the block SHALL, in the next cycle, latch cfg_src_i, cfg_pre_i and cfg_post_i, clear the sample counter, pulse trig_dis_clr_o for 1 cycle and enter PRE.
REQ-021 arm_i SHALL be ignored in PRE, ARM and POST.
REQ-022 In PRE, the sample counter SHALL increment on each dly_valp_i; when counter == latched pre, the block SHALL enter ARM and pulse set_trg_new_o for 1 cycle, with set_trg_src_o = latched src.
REQ-023 If latched pre == 0, the block SHALL leave PRE on the cycle after entry, without waiting for dly_valp_i.
REQ-024 trig_i SHALL be ignored in every state except ARM.
REQ-025 When trig_i is high in ARM, the block SHALL clear the counter and enter POST on the next cycle.
REQ-026 In POST, the counter SHALL increment on each dly_valp_i; when counter == latched post, the block SHALL pulse adc_dly_do_o for 1 cycle and enter DONE.
REQ-027 If latched post == 0, adc_dly_do_o SHALL pulse on the cycle after POST entry.
REQ-028 stop_i SHALL, in any state except IDLE, pulse adc_rst_do_o for 1 cycle and return the FSM to IDLE.
REQ-029 stop_i SHALL take priority over a simultaneous arm_i, trig_i or counter match; stop_i in IDLE SHALL have no effect.
REQ-030 All output pulses SHALL be registered and exactly 1 cycle wide.
REQ-031 set_trg_src_o SHALL hold its value between loads.
REQ-032 The counters SHALL never wrap, because the comparison is an equality check and counting stops on leaving the state.

Reset
REQ-033 While adc_rstn_i is low, the block SHALL asynchronously force state IDLE, all counters and latched configuration to 0, and every output to 0.
REQ-034 Reset asserted mid-acquisition SHALL abandon it without pulsing adc_rst_do_o.

Configuration
REQ-035 When ACQ_TIMESTAMP_EN is defined, the block SHALL add a free-running CNT_W-bit cycle counter (cleared only by reset) and output trig_ts_o, CNT_W bits, which captures that counter on the accepted trig_i in ARM and holds it until the next accepted trigger or reset.
REQ-036 When ACQ_TIMESTAMP_EN is not defined, neither trig_ts_o nor the cycle counter SHALL exist.

Structure
REQ-037 Package rp_acq_pkg SHALL hold the state encoding constants and the trigger source code constants (1 = manual, 2..13 = channel/external/ASG edges).
REQ-038 Sub-module rp_acq_cnt SHALL implement a CNT_W counter with clear, enable and equality match, and SHALL be instantiated once for the sample counter.

Verification
REQ-039 A bench SHALL check: pre=4, post=3, src=2; arm_i, then continuous dly_valp_i -> trig_dis_clr_o 1 cycle after arm, set_trg_new_o with src 2 after 4 samples, trig_i -> adc_dly_do_o after 3 samples, then DONE.
REQ-040 A bench SHALL check: pre=0, post=0 -> set_trg_new_o 2 cycles after arm_i; trig_i -> adc_dly_do_o 2 cycles later.
REQ-041 A bench SHALL check: trig_i pulsed in PRE -> ignored, state stays PRE, then ARM is reached after pre samples.
REQ-042 A bench SHALL check: stop_i and trig_i together in ARM -> adc_rst_do_o pulses, state IDLE, no POST entry.
REQ-043 A bench SHALL check: arm_i pulsed in POST -> ignored; arm_i in DONE -> new acquisition with freshly latched cfg.
REQ-044 A bench SHALL check: adc_rstn_i low during POST -> outputs 0 immediately (asynchronous), state IDLE; with ACQ_TIMESTAMP_EN, trig_ts_o equals the cycle count at the accepted trigger.
